multicycle_controller: RTL and testbench

Parametrised multi-cycle successor to the single-cycle CPU controller. It latches the instruction and sequences FETCH/DECODE/EXEC/MEM/WB through an FSM with req/ack handshakes to instruction and data memory. Datapath controls are asserted only in the correct phase, and it provides a memory timeout error, halt, and retired-instruction counting. It sits between the memories and the existing datapath (ALU, regfile, LR, PC mux), driving the same control names.

---
 rtl/multicycle_controller_if.sv | 13 +
 rtl/multicycle_controller.sv | 172 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Instruction/data memory handshake bundle between the controller and the memories.
interface multicycle_controller_if #(
  parameter int INST_W = 16
);
  logic [INST_W-1:0] inst;
  logic              imem_req;
  logic              imem_ack;
  logic              dmem_req;
  logic              dmem_ack;

  modport master (input inst, imem_ack, dmem_ack, output imem_req, dmem_req);
  modport slave  (output inst, imem_ack, dmem_ack, input imem_req, dmem_req);
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle CPU controller: latches the instruction and sequences FETCH/DECODE/EXEC/MEM/WB,
// pulsing the datapath strobes only in their phase, with memory timeout, halt and retire count.
module multicycle_controller #(
  parameter int INST_W   = 16,
  parameter int OP_W     = 4,
  parameter int ALU_OP_W = 4,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master mem,
  input  logic                    br_mux,
  output logic [ALU_OP_W-1:0]     alu_op,
  output logic [1:0]              pc_sel,
  output logic [1:0]              wb_sel,
  output logic                    wb_demux_sel,
  output logic                    br_sel,
  output logic                    lr_en,
  output logic                    reg_en,
  output logic                    mem_en,
  output logic                    pc_en,
  output logic                    ir_en,
  output logic                    halted,
  output logic                    err,
  output logic [CNT_W-1:0]        retired
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR
  } state_e;

  typedef enum logic [3:0] {
    K_NOP, K_ALU, K_ADDI, K_LD, K_ST, K_BR, K_JMP, K_JAL, K_RET, K_HALT
  } kind_e;

  state_e             r_state, w_next;
  kind_e              w_kind;
  logic [INST_W-1:0]  r_ir;
  logic [WAIT_W-1:0]  r_wait;
  logic [CNT_W-1:0]   r_retired;
  logic [OP_W-1:0]    w_op;
  logic [3:0]         w_op4;
  logic               w_timeout;
  logic               w_unused_ir;

  assign w_op        = r_ir[INST_W-1 -: OP_W];
  assign w_op4       = w_op[3:0];
  assign w_unused_ir = ^r_ir[INST_W-OP_W-1:0];
  assign w_timeout   = (r_wait == WAIT_W'(TIMEOUT - 1));
  assign retired     = r_retired;

  // Opcodes beyond the 4-bit map (wide OP_W) fall through to NOP.
  always_comb begin
    w_kind = K_NOP;
    if ((w_op >> 4) == '0) begin
      case (w_op4)
        4'h0:    w_kind = K_NOP;
        4'h8:    w_kind = K_ADDI;
        4'h9:    w_kind = K_LD;
        4'hA:    w_kind = K_ST;
        4'hB:    w_kind = K_BR;
        4'hC:    w_kind = K_JMP;
        4'hD:    w_kind = K_JAL;
        4'hE:    w_kind = K_RET;
        4'hF:    w_kind = K_HALT;
        default: w_kind = K_ALU;
      endcase
    end
  end

  // NOTE: async reset, and every register uses <= so all of them sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_ir      <= '0;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (ir_en) r_ir <= mem.inst;
      if (w_next != r_state)                          r_wait <= '0;
      else if (r_state == S_FETCH || r_state == S_MEM) r_wait <= r_wait + WAIT_W'(1);
      if (pc_en) r_retired <= r_retired + CNT_W'(1);
    end
  end

  // NOTE: every output gets a default first, so no path through the case infers a latch.
  always_comb begin
    w_next       = r_state;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    alu_op       = '0;
    pc_sel       = 2'd0;
    wb_sel       = 2'd0;
    wb_demux_sel = 1'b0;
    br_sel       = 1'b0;
    lr_en        = 1'b0;
    reg_en       = 1'b0;
    mem_en       = 1'b0;
    pc_en        = 1'b0;
    ir_en        = 1'b0;
    halted       = (r_state == S_HALT);
    err          = (r_state == S_ERROR);

    // Everything stays quiet while reset is held, even though the state already reads FETCH.
    if (rst_n) begin
      if (r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
        case (w_kind)
          K_ALU:        alu_op = ALU_OP_W'(w_op4);
          K_ADDI, K_ST: alu_op = ALU_OP_W'(1);
          K_LD: begin
            alu_op = ALU_OP_W'(1);
            wb_sel = 2'd1;
          end
          K_BR:  pc_sel = (r_state == S_EXEC && br_mux) ? 2'd1 : 2'd0;
          K_JMP: pc_sel = 2'd2;
          K_JAL: begin
            pc_sel       = 2'd2;
            wb_sel       = 2'd3;
            wb_demux_sel = 1'b1;
          end
          K_RET:   pc_sel = 2'd3;
          default: ;
        endcase
      end

      case (r_state)
        S_FETCH: begin
          mem.imem_req = 1'b1;
          if (mem.imem_ack) begin
            ir_en  = 1'b1;
            w_next = S_DECODE;
          end else if (w_timeout) begin
            w_next = S_ERROR;
          end
        end
        S_DECODE: w_next = S_EXEC;
        S_EXEC: begin
          case (w_kind)
            K_ALU, K_ADDI: w_next = S_WB;
            K_LD, K_ST:    w_next = S_MEM;
            K_HALT:        w_next = S_HALT;
            default: begin
              br_sel = (w_kind == K_BR) && br_mux;
              lr_en  = (w_kind == K_JAL);
              pc_en  = 1'b1;
              w_next = S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          mem.dmem_req = 1'b1;
          mem_en       = (w_kind == K_ST);
          if (mem.dmem_ack) begin
            pc_en  = (w_kind == K_ST);
            w_next = (w_kind == K_ST) ? S_FETCH : S_WB;
          end else if (w_timeout) begin
            w_next = S_ERROR;
          end
        end
        S_WB: begin
          reg_en = 1'b1;
          pc_en  = 1'b1;
          w_next = S_FETCH;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (TIMEOUT=4): cycle-by-cycle strobe/control checks.
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       br_mux;
  logic [3:0] alu_op;
  logic [1:0] pc_sel, wb_sel;
  logic       wb_demux_sel, br_sel, lr_en, reg_en, mem_en, pc_en, ir_en, halted, err;
  logic [15:0] retired;
  int n_cmp = 0;
  int n_err = 0;

  multicycle_controller_if #(.INST_W(16)) mem_bus ();

  multicycle_controller #(
    .INST_W(16), .OP_W(4), .ALU_OP_W(4), .TIMEOUT(4), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem(mem_bus), .br_mux(br_mux),
    .alu_op(alu_op), .pc_sel(pc_sel), .wb_sel(wb_sel), .wb_demux_sel(wb_demux_sel),
    .br_sel(br_sel), .lr_en(lr_en), .reg_en(reg_en), .mem_en(mem_en), .pc_en(pc_en),
    .ir_en(ir_en), .halted(halted), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] IREQ = 10'h200, DREQ = 10'h100, IRE = 10'h080, PCE = 10'h040,
                         REGE = 10'h020, LRE = 10'h010, MEME = 10'h008, BRS = 10'h004,
                         HLT  = 10'h002, ERR = 10'h001;

  wire [9:0] w_st  = {mem_bus.imem_req, mem_bus.dmem_req, ir_en, pc_en, reg_en, lr_en,
                      mem_en, br_sel, halted, err};
  wire [8:0] w_ctl = {alu_op, pc_sel, wb_sel, wb_demux_sel};

  function automatic logic [8:0] ctl(input int a, input int p, input int w, input int d);
    return {4'(a), 2'(p), 2'(w), 1'(d)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [9:0] st, input logic [8:0] c);
    check({tag, ".st"}, 32'(w_st), 32'(st));
    check({tag, ".ctl"}, 32'(w_ctl), 32'(c));
  endtask

  // Drive this cycle's inputs just after the edge, then let the outputs settle.
  task automatic cyc(input logic ia, input logic da, input logic bm);
    @(posedge clk);
    #1;
    mem_bus.imem_ack = ia;
    mem_bus.dmem_ack = da;
    br_mux           = bm;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; br_mux = 1'b0;
    mem_bus.inst = 16'h1000; mem_bus.imem_ack = 1'b1; mem_bus.dmem_ack = 1'b1;

    cyc(1, 1, 0); chk("rst0", '0, '0); check("rst0.ret", 32'(retired), 0);
    cyc(1, 1, 1); chk("rst1", '0, '0);

    rst_n = 1'b1; #1;
    chk("add.F", IREQ | IRE, '0);
    cyc(1, 1, 0); chk("add.D", '0, ctl(1, 0, 0, 0));
    cyc(1, 1, 0); chk("add.E", '0, ctl(1, 0, 0, 0));
    cyc(1, 1, 0); chk("add.W", REGE | PCE, ctl(1, 0, 0, 0));
    check("add.W.ret", 32'(retired), 0);

    mem_bus.inst = 16'hB000;
    cyc(1, 1, 1); chk("br1.F", IREQ | IRE, '0); check("br1.F.ret", 32'(retired), 1);
    cyc(1, 1, 1); chk("br1.D", '0, '0);
    cyc(1, 1, 1); chk("br1.E", PCE | BRS, ctl(0, 1, 0, 0));
    cyc(1, 1, 1); chk("br0.F", IREQ | IRE, '0); check("br0.F.ret", 32'(retired), 2);
    cyc(1, 1, 1); chk("br0.D", '0, '0);
    cyc(1, 1, 0); chk("br0.E", PCE, '0);

    mem_bus.inst = 16'h9000;
    cyc(1, 1, 0); chk("ld.F", IREQ | IRE, '0); check("ld.F.ret", 32'(retired), 3);
    cyc(1, 1, 0); chk("ld.D", '0, ctl(1, 0, 1, 0));
    cyc(1, 1, 0); chk("ld.E", '0, ctl(1, 0, 1, 0));
    cyc(1, 0, 0); chk("ld.M1", DREQ, ctl(1, 0, 1, 0));
    cyc(1, 0, 0); chk("ld.M2", DREQ, ctl(1, 0, 1, 0));
    cyc(1, 0, 0); chk("ld.M3", DREQ, ctl(1, 0, 1, 0));
    cyc(1, 1, 0); chk("ld.M4", DREQ, ctl(1, 0, 1, 0));
    cyc(1, 1, 0); chk("ld.W", REGE | PCE, ctl(1, 0, 1, 0));

    mem_bus.inst = 16'hA000;
    cyc(1, 1, 0); chk("st.F", IREQ | IRE, '0); check("st.F.ret", 32'(retired), 4);
    cyc(1, 1, 0); chk("st.D", '0, ctl(1, 0, 0, 0));
    cyc(1, 1, 0); chk("st.E", '0, ctl(1, 0, 0, 0));
    cyc(1, 0, 0); chk("st.M1", DREQ | MEME, ctl(1, 0, 0, 0));
    cyc(1, 0, 0); chk("st.M2", DREQ | MEME, ctl(1, 0, 0, 0));
    cyc(1, 0, 0); chk("st.M3", DREQ | MEME, ctl(1, 0, 0, 0));
    cyc(1, 1, 0); chk("st.M4", DREQ | MEME | PCE, ctl(1, 0, 0, 0));

    mem_bus.inst = 16'hD000;
    cyc(1, 1, 0); chk("jal.F", IREQ | IRE, '0); check("jal.F.ret", 32'(retired), 5);
    cyc(1, 1, 0); chk("jal.D", '0, ctl(0, 2, 3, 1));
    cyc(1, 1, 0); chk("jal.E", PCE | LRE, ctl(0, 2, 3, 1));
    mem_bus.inst = 16'hE000;
    cyc(1, 1, 0); chk("ret.F", IREQ | IRE, '0); check("ret.F.ret", 32'(retired), 6);
    cyc(1, 1, 0); chk("ret.D", '0, ctl(0, 3, 0, 0));
    cyc(1, 1, 0); chk("ret.E", PCE, ctl(0, 3, 0, 0));

    mem_bus.inst = 16'h7123;
    cyc(1, 1, 0); chk("shr.F", IREQ | IRE, '0); check("shr.F.ret", 32'(retired), 7);
    cyc(1, 1, 0); chk("shr.D", '0, ctl(7, 0, 0, 0));
    cyc(1, 1, 0); chk("shr.E", '0, ctl(7, 0, 0, 0));
    cyc(1, 1, 0); chk("shr.W", REGE | PCE, ctl(7, 0, 0, 0));
    mem_bus.inst = 16'h0000;
    cyc(1, 1, 0); chk("nop.F", IREQ | IRE, '0); check("nop.F.ret", 32'(retired), 8);
    cyc(1, 1, 0); chk("nop.D", '0, '0);
    cyc(1, 1, 0); chk("nop.E", PCE, '0);

    // Fetch ack arrives in the last allowed wait cycle; early dmem_ack is ignored.
    mem_bus.inst = 16'hF000;
    cyc(0, 1, 0); chk("late.F1", IREQ, '0); check("late.F1.ret", 32'(retired), 9);
    cyc(0, 1, 0); chk("late.F2", IREQ, '0);
    cyc(0, 1, 0); chk("late.F3", IREQ, '0);
    cyc(1, 0, 0); chk("late.F4", IREQ | IRE, '0);
    cyc(1, 1, 0); chk("halt.D", '0, '0);
    cyc(1, 1, 0); chk("halt.E", '0, '0);
    cyc(1, 1, 0); chk("halt.H1", HLT, '0);
    cyc(1, 1, 1); chk("halt.H2", HLT, '0); check("halt.ret", 32'(retired), 9);

    rst_n = 1'b0; #1;
    chk("halt.rst", '0, '0);
    cyc(0, 0, 0);
    rst_n = 1'b1; #1;
    chk("to.F1", IREQ, '0); check("to.F1.ret", 32'(retired), 0);
    cyc(0, 0, 0); chk("to.F2", IREQ, '0);
    cyc(0, 0, 0); chk("to.F3", IREQ, '0);
    cyc(0, 0, 0); chk("to.F4", IREQ, '0);
    cyc(0, 0, 0); chk("to.E1", ERR, '0);
    cyc(1, 1, 0); chk("to.E2", ERR, '0);

    rst_n = 1'b0; #1;
    mem_bus.inst = 16'h9000;
    cyc(1, 1, 0);
    rst_n = 1'b1; #1;
    chk("ab.F", IREQ | IRE, '0);
    cyc(1, 1, 0); chk("ab.D", '0, ctl(1, 0, 1, 0));
    cyc(1, 1, 0); chk("ab.E", '0, ctl(1, 0, 1, 0));
    cyc(1, 0, 0); chk("ab.M1", DREQ, ctl(1, 0, 1, 0));
    rst_n = 1'b0; #1;
    chk("ab.rst", '0, '0); check("ab.rst.ret", 32'(retired), 0);
    cyc(1, 1, 0); chk("ab.hold", '0, '0);
    mem_bus.imem_ack = 1'b0;
    rst_n = 1'b1; #1;
    chk("ab.F2", IREQ, '0); check("ab.F2.ret", 32'(retired), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
